keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad by time-multiplexing its columns, the input-side counterpart of the
//  two-digit display multiplexer. It debounces presses and releases, and emits one key code per press.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/keypad_scanner.sv | 140 ++++++++++++++
 tb/tb_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map, row decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Indexed [row][col]; rows and columns are numbered from bit 0 of the pins.
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // A press counts only when exactly one active-low row is pulled down.
  function automatic logic onehot_valid(input logic [3:0] rows_n);
    logic [3:0] low;
    low = ~rows_n;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows_n);
    logic [1:0] idx;
    case (rows_n)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row pins.
module sync_2ff (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Reset to all-ones so released rows never look like a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and one key_valid pulse per press.
// Optional KEYPAD_HISTORY_EN adds digit_new/digit_old, the last two accepted key codes.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT     = 100_000,
  parameter int DEBOUNCE_COUNT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
`ifdef KEYPAD_HISTORY_EN
  ,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
`endif
);

  localparam int SCW = $clog2(SCAN_COUNT);
  localparam int DBW = $clog2(DEBOUNCE_COUNT);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_COUNT - 1);
  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_COUNT - 1);

  logic [3:0]     rows_s;
  state_e         state_q;
  logic [1:0]     col_idx_q;
  logic [SCW-1:0] scan_cnt_q;
  logic [DBW-1:0] deb_cnt_q;
  logic [3:0]     row_pat_q;
  logic [3:0]     key_code_q;
  logic           key_valid_q;
  logic           key_held_q;
  logic [1:0]     col_idx_d;
  logic [3:0]     key_lookup_d;
`ifdef KEYPAD_HISTORY_EN
  logic [3:0]     digit_new_q;
  logic [3:0]     digit_old_q;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rows),
    .q_o   (rows_s)
  );

  assign col_idx_d    = col_idx_q + 2'd1;
  assign key_lookup_d = KEYMAP[row_index(row_pat_q)][col_idx_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      row_pat_q   <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_HISTORY_EN
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          // Rows are only trusted at the end of the window, after the column drive has settled.
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (onehot_valid(rows_s)) begin
              row_pat_q <= rows_s;
              deb_cnt_q <= '0;
              state_q   <= DEBOUNCE;
            end else begin
              col_idx_q <= col_idx_d;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rows_s != row_pat_q) begin
            col_idx_q  <= col_idx_d;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q   <= '0;
            key_code_q  <= key_lookup_d;
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state_q     <= HELD;
`ifdef KEYPAD_HISTORY_EN
            digit_old_q <= digit_new_q;
            digit_new_q <= key_lookup_d;
`endif
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        HELD: begin
          // Column stays frozen; extra keys in this column are ignored until a clean release.
          if (rows_s == 4'hF) begin
            deb_cnt_q <= '0;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          if (rows_s != 4'hF) begin
            deb_cnt_q <= '0;
            state_q   <= HELD;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q  <= '0;
            key_held_q <= 1'b0;
            col_idx_q  <= col_idx_d;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign cols      = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
`ifdef KEYPAD_HISTORY_EN
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_COUNT=4, DEBOUNCE_COUNT=8) with a behavioural keypad matrix.
module tb_keypad_scanner;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
    logic [3:0] cols_exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
`ifdef KEYPAD_HISTORY_EN
  logic [3:0]  digit_new;
  logic [3:0]  digit_old;
`endif

  logic [15:0] keys_down;
  logic [3:0]  exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          pulses = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_COUNT     (4),
    .DEBOUNCE_COUNT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
`ifdef KEYPAD_HISTORY_EN
    ,
    .digit_new (digit_new),
    .digit_old (digit_old)
`endif
  );

  // Keypad matrix: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One clock; any key_valid is matched against the scoreboard.
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_key_valid: got key_code %h, required no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", key_code, e);
        $display("key accepted: key_code=%h expected=%h", key_code, e);
      end
    end
  endtask

  task automatic wait_pulses(input string name, input int target);
    for (int i = 0; i < 300 && pulses < target; i++) step();
    check_int(name, pulses, target);
  endtask

  task automatic wait_release(input string name);
    for (int i = 0; i < 100 && key_held !== 1'b0; i++) step();
    check(name, {3'b0, key_held}, 4'h0);
  endtask

  task automatic press_and_release(input int r, input int c, input logic [3:0] code);
    pulses = 0;
    exp_q.push_back(code);
    keys_down = 16'h0;
    keys_down[r*4+c] = 1'b1;
    wait_pulses("press_pulse", 1);
    keys_down = 16'h0;
    wait_release("press_release");
  endtask

  initial begin
    vec_t       tbl[16];
    logic [3:0] codes[16];
    logic [3:0] e;
    logic [3:0] prev_cols;
    int         changes;
    int         run;

    codes = '{4'h1, 4'h2, 4'h3, 4'hA,
              4'h4, 4'h5, 4'h6, 4'hB,
              4'h7, 4'h8, 4'h9, 4'hC,
              4'hE, 4'h0, 4'hF, 4'hD};
    for (int i = 0; i < 16; i++) begin
      e = 4'b0001 << (i % 4);
      tbl[i] = '{i / 4, i % 4, codes[i], ~e};
    end

    keys_down = 16'h0;
    reset = 1'b0;
    repeat (3) step();
    check("reset_cols", cols, 4'b1110);
    check("reset_key_code", key_code, 4'h0);
    check("reset_key_valid", {3'b0, key_valid}, 4'h0);
    check("reset_key_held", {3'b0, key_held}, 4'h0);
`ifdef KEYPAD_HISTORY_EN
    check("reset_digit_new", digit_new, 4'h0);
    check("reset_digit_old", digit_old, 4'h0);
`endif
    reset = 1'b1;

    // Idle scan: column advances every 4 clocks starting from column 0.
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      e = 4'b0001 << ((k / 4) % 4);
      check("idle_cols", cols, ~e);
    end
    check_int("idle_no_pulse", pulses, 0);

    // Every key once: one pulse, correct code, column frozen, no auto-repeat, clean release.
    for (int i = 0; i < 16; i++) begin
      pulses = 0;
      exp_q.push_back(tbl[i].code);
      keys_down = 16'h0;
      keys_down[tbl[i].row*4 + tbl[i].col] = 1'b1;
      wait_pulses("key_pulse", 1);
      check("key_held_on", {3'b0, key_held}, 4'h1);
      check("frozen_cols", cols, tbl[i].cols_exp);
      repeat (30) step();
      check_int("no_repeat", pulses, 1);
      check("frozen_cols_late", cols, tbl[i].cols_exp);
      keys_down = 16'h0;
      wait_release("key_release");
    end

    // Bounce on key '5': 3-clock toggles must never be accepted.
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      keys_down = (k % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (3) step();
    end
    check_int("bounce_no_pulse", pulses, 0);
    exp_q.push_back(4'h5);
    keys_down = 16'h0020;
    wait_pulses("bounce_single_pulse", 1);
    repeat (20) step();
    check_int("bounce_one_pulse", pulses, 1);
    keys_down = 16'h0;
    wait_release("bounce_release");

    // Two rows low in column 0 ('1' and '4'): ignored, scanning keeps moving.
    pulses = 0;
    changes = 0;
    keys_down = 16'h0011;
    prev_cols = cols;
    for (int k = 0; k < 40; k++) begin
      step();
      if (cols !== prev_cols) changes++;
      prev_cols = cols;
    end
    check_int("multi_row_no_pulse", pulses, 0);
    check_int("multi_row_col_changes", changes, 10);
    keys_down = 16'h0;

    // Release glitch while holding '5'.
    pulses = 0;
    exp_q.push_back(4'h5);
    keys_down = 16'h0020;
    wait_pulses("glitch_press", 1);
    keys_down = 16'h0;
    repeat (4) step();
    keys_down = 16'h0020;
    repeat (30) step();
    check_int("glitch_no_new_pulse", pulses, 1);
    check("glitch_key_held", {3'b0, key_held}, 4'h1);
    check("glitch_cols", cols, 4'b1101);
    keys_down = 16'h0;
    wait_release("glitch_release");

    // Reset during DEBOUNCE of key '1', after '2' has left key_code nonzero.
    press_and_release(0, 1, 4'h2);
    keys_down = 16'h0001;
    run = 0;
    for (int k = 0; k < 200 && run < 5; k++) begin
      step();
      run = (cols === 4'b1110) ? run + 1 : 0;
    end
    check_int("reached_debounce", run, 5);
    reset = 1'b0;
    step();
    check("rst_mid_cols", cols, 4'b1110);
    check("rst_mid_key_code", key_code, 4'h0);
    check("rst_mid_key_held", {3'b0, key_held}, 4'h0);
    reset = 1'b1;
    pulses = 0;
    exp_q.push_back(4'h1);
    wait_pulses("reaccept_after_reset", 1);
    check("reaccept_held", {3'b0, key_held}, 4'h1);
    keys_down = 16'h0;
    wait_release("reaccept_release");

    press_and_release(0, 1, 4'h2);
`ifdef KEYPAD_HISTORY_EN
    check("digit_old", digit_old, 4'h1);
    check("digit_new", digit_new, 4'h2);
`endif
    check_int("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
